// File: rtl/bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_scheduler
// Brief    : Single write-port sequencer for the local-history predictor tables:
//            post-reset/flush init sweep plus FIFO-buffered M-stage updates.
// Revision : 1.0
// ============================================================================
module bp_update_scheduler #(
  parameter int         PHT_DEPTH  = 7,
  parameter int         BHT_DEPTH  = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush_req,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [PHT_DEPTH-1:0] upd_pht_idx,
  input  logic [BHT_DEPTH-1:0] upd_bht_idx,
  input  logic                 upd_taken,
  output logic                 wr_valid,
  output logic                 wr_init,
  output logic [PHT_DEPTH-1:0] wr_pht_idx,
  output logic [BHT_DEPTH-1:0] wr_bht_idx,
  output logic                 wr_taken,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  localparam int                 c_EW        = PHT_DEPTH + BHT_DEPTH + 1;
  localparam int                 c_PW        = $clog2(FIFO_DEPTH);
  localparam logic [c_PW:0]      c_FIFO_FULL = (c_PW + 1)'(FIFO_DEPTH);
  localparam logic [PHT_DEPTH-1:0] c_LAST_IDX = {PHT_DEPTH{1'b1}};

  if (BHT_DEPTH > PHT_DEPTH || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || $bits(INIT_STATE) != 2) begin : g_param_check
    $error("bp_update_scheduler: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  logic [PHT_DEPTH-1:0]  r_sweep_cnt;
  logic [c_EW-1:0]       r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_PW:0]         r_count;
  logic [15:0]           r_drop_cnt;
  logic                  r_wr_valid;
  logic                  r_wr_init;
  logic [PHT_DEPTH-1:0]  r_wr_pht_idx;
  logic [BHT_DEPTH-1:0]  r_wr_bht_idx;
  logic                  r_wr_taken;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic [c_EW-1:0]       w_head;

  assign upd_ready = (r_state == ST_RUN) && (r_count < c_FIFO_FULL);
  assign busy      = (r_state == ST_SWEEP);

  // A flush discards the offered update too, so it counts as a drop.
  assign w_push = upd_valid && upd_ready && !flush_req;
  assign w_pop  = (r_state == ST_RUN) && !flush_req && (r_count != '0);
  assign w_drop = upd_valid && (!upd_ready || flush_req);
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {upd_pht_idx, upd_bht_idx, upd_taken};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_SWEEP;
      r_sweep_cnt  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_cnt   <= '0;
      r_wr_valid   <= 1'b0;
      r_wr_init    <= 1'b0;
      r_wr_pht_idx <= '0;
      r_wr_bht_idx <= '0;
      r_wr_taken   <= 1'b0;
    end else begin
      if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      case (r_state)
        ST_SWEEP: begin
          if (flush_req) begin
            r_sweep_cnt <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_init   <= 1'b0;
          end else begin
            r_wr_valid   <= 1'b1;
            r_wr_init    <= 1'b1;
            r_wr_pht_idx <= r_sweep_cnt;
            r_wr_bht_idx <= r_sweep_cnt[BHT_DEPTH-1:0];
            r_wr_taken   <= 1'b0;
            r_sweep_cnt  <= r_sweep_cnt + 1'b1;
            if (r_sweep_cnt == c_LAST_IDX) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          if (flush_req) begin
            r_state     <= ST_SWEEP;
            r_sweep_cnt <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_init   <= 1'b0;
          end else begin
            r_wr_init <= 1'b0;
            if (w_pop) begin
              r_wr_valid                 <= 1'b1;
              {r_wr_pht_idx, r_wr_bht_idx, r_wr_taken} <= w_head;
              r_rd_ptr                   <= r_rd_ptr + 1'b1;
            end else begin
              r_wr_valid <= 1'b0;
            end
            if (w_push) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + 1'b1;
              2'b01:   r_count <= r_count - 1'b1;
              default: r_count <= r_count;
            endcase
          end
        end
      endcase
    end
  end

  assign wr_valid   = r_wr_valid;
  assign wr_init    = r_wr_init;
  assign wr_pht_idx = r_wr_pht_idx;
  assign wr_bht_idx = r_wr_bht_idx;
  assign wr_taken   = r_wr_taken;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_scheduler
// Brief    : Directed + random stimulus against a queue-based predictor-write model.
// Revision : 1.0
// ============================================================================
module tb_bp_update_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_req;
  logic        upd_valid;
  logic        upd_ready;
  logic [6:0]  upd_pht_idx;
  logic [2:0]  upd_bht_idx;
  logic        upd_taken;
  logic        wr_valid;
  logic        wr_init;
  logic [6:0]  wr_pht_idx;
  logic [2:0]  wr_bht_idx;
  logic        wr_taken;
  logic        busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  bp_update_scheduler #(
    .PHT_DEPTH (7),
    .BHT_DEPTH (3),
    .FIFO_DEPTH(4),
    .INIT_STATE(2'b01)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush_req  (flush_req),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pht_idx(upd_pht_idx),
    .upd_bht_idx(upd_bht_idx),
    .upd_taken  (upd_taken),
    .wr_valid   (wr_valid),
    .wr_init    (wr_init),
    .wr_pht_idx (wr_pht_idx),
    .wr_bht_idx (wr_bht_idx),
    .wr_taken   (wr_taken),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sweep position, pending-update queue, expected write.
  bit          m_sweep;
  int          m_idx;
  logic [10:0] m_q[$];
  int          m_drop;
  bit          e_valid;
  bit          e_init;
  int          e_pht;
  int          e_bht;
  bit          e_taken;
  int          init_writes;
  int          upd_writes;

  task automatic model_reset();
    m_sweep = 1'b1;
    m_idx   = 0;
    m_q.delete();
    m_drop  = 0;
    e_valid = 1'b0;
    e_init  = 1'b0;
    e_pht   = 0;
    e_bht   = 0;
    e_taken = 1'b0;
  endtask

  task automatic model_step();
    bit          ready;
    logic [10:0] ent;
    ready = !m_sweep && (m_q.size() < 4);
    if (upd_valid && (!ready || flush_req) && m_drop < 65535) m_drop++;
    if (m_sweep) begin
      if (flush_req) begin
        m_idx   = 0;
        e_valid = 1'b0;
      end else begin
        e_valid = 1'b1;
        e_init  = 1'b1;
        e_pht   = m_idx;
        e_bht   = m_idx % 8;
        e_taken = 1'b0;
        m_idx++;
        if (m_idx == 128) m_sweep = 1'b0;
      end
    end else if (flush_req) begin
      m_sweep = 1'b1;
      m_idx   = 0;
      m_q.delete();
      e_valid = 1'b0;
    end else begin
      if (m_q.size() > 0) begin
        ent     = m_q.pop_front();
        e_valid = 1'b1;
        e_init  = 1'b0;
        e_pht   = int'(ent[10:4]);
        e_bht   = int'(ent[3:1]);
        e_taken = ent[0];
      end else begin
        e_valid = 1'b0;
      end
      if (upd_valid && ready) m_q.push_back({upd_pht_idx, upd_bht_idx, upd_taken});
    end
  endtask

  task automatic compare_all();
    check_eq("wr_valid", 32'(wr_valid), 32'(e_valid));
    if (e_valid) begin
      check_eq("wr_init", 32'(wr_init), 32'(e_init));
      check_eq("wr_pht_idx", 32'(wr_pht_idx), 32'(e_pht));
      check_eq("wr_bht_idx", 32'(wr_bht_idx), 32'(e_bht));
      check_eq("wr_taken", 32'(wr_taken), 32'(e_taken));
    end
    check_eq("busy", 32'(busy), 32'(m_sweep));
    check_eq("upd_ready", 32'(upd_ready), 32'(!m_sweep && m_q.size() < 4));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (wr_valid && wr_init) init_writes++;
    if (wr_valid && !wr_init) upd_writes++;
  endtask

  // Called at a negedge: drive, let one edge happen, compare at the next negedge.
  task automatic cycle(input logic v, input logic [6:0] p, input logic [2:0] b,
                       input logic t, input logic f);
    upd_valid   = v;
    upd_pht_idx = p;
    upd_bht_idx = b;
    upd_taken   = t;
    flush_req   = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] rp;
    logic [2:0] rb;
    resetn      = 1'b0;
    flush_req   = 1'b0;
    upd_valid   = 1'b0;
    upd_pht_idx = '0;
    upd_bht_idx = '0;
    upd_taken   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_upd_ready", 32'(upd_ready), 32'd0);
    resetn = 1'b1;

    // Init sweep with no traffic.
    init_writes = 0;
    idle(130);
    check_eq("sweep_len", 32'(init_writes), 32'd128);
    check_eq("run_busy", 32'(busy), 32'd0);
    check_eq("run_ready", 32'(upd_ready), 32'd1);

    // Single update, one-cycle latency.
    cycle(1'b1, 7'h2A, 3'd5, 1'b1, 1'b0);
    cycle(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    check_eq("single_pht", 32'(wr_pht_idx), 32'h2A);
    idle(2);

    // Six back-to-back updates, drained in order without gaps.
    upd_writes = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 7'(10 + i), 3'(i), 1'(i), 1'b0);
    idle(3);
    check_eq("burst_writes", 32'(upd_writes), 32'd6);

    // Flush, then offer updates during the sweep.
    cycle(1'b0, 7'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 7'(i), 3'(i), 1'b1, 1'b0);
    check_eq("sweep_drops", 32'(drop_cnt), 32'd10);
    idle(125);

    // Queued updates then flush with an update offered in the same cycle.
    cycle(1'b1, 7'h11, 3'd1, 1'b1, 1'b0);
    cycle(1'b1, 7'h22, 3'd2, 1'b0, 1'b0);
    cycle(1'b1, 7'h33, 3'd3, 1'b1, 1'b0);
    cycle(1'b1, 7'h44, 3'd4, 1'b1, 1'b1);
    check_eq("flush_nowrite", 32'(wr_valid), 32'd0);
    check_eq("flush_drop", 32'(drop_cnt), 32'd11);

    // Flush again at sweep index 60.
    idle(60);
    init_writes = 0;
    cycle(1'b0, 7'd0, 3'd0, 1'b0, 1'b1);
    check_eq("resweep_gap", 32'(wr_valid), 32'd0);
    idle(130);
    check_eq("resweep_len", 32'(init_writes), 32'd128);

    // Asynchronous reset in the middle of a sweep.
    cycle(1'b0, 7'd0, 3'd0, 1'b0, 1'b1);
    idle(20);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_wr_valid", 32'(wr_valid), 32'd0);
    check_eq("async_wr_init", 32'(wr_init), 32'd0);
    check_eq("async_pht", 32'(wr_pht_idx), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd1);
    check_eq("async_drop", 32'(drop_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    idle(130);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      rp = 7'($urandom);
      rb = 3'($urandom);
      cycle(1'($urandom_range(0, 99) < 70), rp, rb, 1'($urandom),
            1'($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
